// File: rtl/uart_aim_rx.sv
// 8N1 UART receiver with an ASCII "d<num>" / "q<num>" line parser.
// Each committed command updates the selected signed current target.
module uart_aim_rx #(
    parameter logic [15:0] CLK_DIV = 16'd320,
    parameter logic [15:0] LIMIT   = 16'd4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_uart_rx,
    output logic               o_en,
    output logic signed [15:0] o_id_aim,
    output logic signed [15:0] o_iq_aim,
    output logic               o_err
);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_e;
    typedef enum logic [1:0] {P_IDLE, P_SIGN, P_DIGIT, P_DISCARD} p_state_e;

    localparam logic [15:0] HALF = CLK_DIV / 16'd2;

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   r_state_q, r_state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        byte_valid, frame_err;

    p_state_e    p_state_q, p_state_d;
    logic        sel_q, sel_d;
    logic        neg_q, neg_d;
    logic [16:0] acc_q, acc_d;
    logic [2:0]  ndig_q, ndig_d;
    logic        commit, perr;

    logic signed [15:0] id_q, iq_q;
    logic        en_q, err_q;

    logic        is_digit, is_term, is_sep;
    logic [3:0]  digit;
    logic [20:0] acc_prod;
    logic [16:0] acc_sat;
    logic [15:0] mag, value;

    // Receiver: counter runs down to zero, each zero is a sample point.
    always_comb begin
        r_state_d  = r_state_q;
        cnt_d      = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    r_state_d = R_START;
                    cnt_d     = HALF - 16'd1;
                end
            end
            R_START: begin
                if (cnt_q == 16'd0) begin
                    if (rx_sync_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_state_d = R_DATA;
                        cnt_d     = CLK_DIV - 16'd1;
                        bit_d     = 3'd0;
                    end
                end
            end
            R_DATA: begin
                if (cnt_q == 16'd0) begin
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    cnt_d   = CLK_DIV - 16'd1;
                    if (bit_q == 3'd7) begin
                        r_state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            R_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                        r_state_d  = R_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        r_state_d = R_WAITHI;
                    end
                end
            end
            R_WAITHI: begin
                if (rx_sync_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign is_digit = (shreg_q >= 8'h30) && (shreg_q <= 8'h39);
    assign is_term  = (shreg_q == 8'h0D) || (shreg_q == 8'h0A);
    assign is_sep   = is_term || (shreg_q == 8'h20);
    assign digit    = shreg_q[3:0];
    assign acc_prod = ({4'd0, acc_q} * 21'd10) + {17'd0, digit};
    assign acc_sat  = (acc_prod > 21'd99999) ? 17'd99999 : acc_prod[16:0];
    assign mag      = (acc_q > {1'b0, LIMIT}) ? LIMIT : acc_q[15:0];
    assign value    = neg_q ? (16'd0 - mag) : mag;

    always_comb begin
        p_state_d = p_state_q;
        sel_d     = sel_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        ndig_d    = ndig_q;
        commit    = 1'b0;
        perr      = 1'b0;
        if (byte_valid) begin
            case (p_state_q)
                P_IDLE: begin
                    if (shreg_q == 8'h64 || shreg_q == 8'h44 ||
                        shreg_q == 8'h71 || shreg_q == 8'h51) begin
                        sel_d     = (shreg_q == 8'h71) || (shreg_q == 8'h51);
                        neg_d     = 1'b0;
                        acc_d     = '0;
                        ndig_d    = '0;
                        p_state_d = P_SIGN;
                    end else if (!is_sep) begin
                        perr      = 1'b1;
                        p_state_d = P_DISCARD;
                    end
                end
                P_SIGN: begin
                    if (shreg_q == 8'h2D && !neg_q) begin
                        neg_d = 1'b1;
                    end else if (is_digit) begin
                        acc_d     = {13'd0, digit};
                        ndig_d    = 3'd1;
                        p_state_d = P_DIGIT;
                    end else if (is_term) begin
                        perr      = 1'b1;
                        p_state_d = P_IDLE;
                    end else begin
                        perr      = 1'b1;
                        p_state_d = P_DISCARD;
                    end
                end
                P_DIGIT: begin
                    if (is_digit) begin
                        if (ndig_q == 3'd5) begin
                            perr      = 1'b1;
                            p_state_d = P_DISCARD;
                        end else begin
                            acc_d  = acc_sat;
                            ndig_d = ndig_q + 3'd1;
                        end
                    end else if (is_term) begin
                        commit    = 1'b1;
                        p_state_d = P_IDLE;
                    end else begin
                        perr      = 1'b1;
                        p_state_d = P_DISCARD;
                    end
                end
                P_DISCARD: begin
                    if (is_term) begin
                        p_state_d = P_IDLE;
                    end
                end
                default: p_state_d = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            p_state_q <= P_IDLE;
            sel_q     <= 1'b0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            ndig_q    <= '0;
            id_q      <= '0;
            iq_q      <= '0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            r_state_q <= r_state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            p_state_q <= p_state_d;
            sel_q     <= sel_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            ndig_q    <= ndig_d;
            en_q      <= commit;
            err_q     <= frame_err | perr;
            if (commit && !sel_q) id_q <= value;
            if (commit && sel_q)  iq_q <= value;
        end
    end

    assign o_en     = en_q;
    assign o_err    = err_q;
    assign o_id_aim = id_q;
    assign o_iq_aim = iq_q;

endmodule
